// File: rtl/log_converter_pkg.sv
// Shared types and constants for the log_converter fixed-point logarithm engine.
package log_converter_pkg;

  typedef enum logic [1:0] {
    LOG2  = 2'd0,
    LN    = 2'd1,
    LOG10 = 2'd2,
    RSVD  = 2'd3
  } log_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    FRAC,
    SCALE,
    DONE
  } state_t;

  // Base-change multipliers in Q0.16: ln(2) and log10(2).
  localparam int unsigned LN2_Q16     = 45426;
  localparam int unsigned LOG10_2_Q16 = 19728;
  localparam int          SCALE_SHIFT = 16;

  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/log_converter_if.sv
// Request/response bundle for log_converter: master drives requests, slave returns tagged results.
interface log_converter_if #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 12,
  parameter int CW    = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_W-1:0]         in_data;
  logic [CW-1:0]           in_chan;
  logic [1:0]              in_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [CW-1:0]           out_chan;
  logic                    out_sat;
  logic                    out_zero;

  modport master (
    output in_valid, in_data, in_chan, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_chan, out_sat, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_chan, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_chan, out_sat, out_zero
  );
endinterface

// File: rtl/log_converter_lod.sv
// lod_priority: combinational leading-one detector; index of the highest set bit plus an all-zero flag.
module lod_priority #(
  parameter int W  = 24,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] index,
  output logic          zero
);
  always_comb begin
    index = '0;
    zero  = (vec == '0);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) index = IW'(i);
    end
  end
endmodule

// File: rtl/log_converter.sv
// Multi-channel fixed-point log2/ln/log10 engine: leading-one normalise, then one mantissa squaring per fraction bit.
// Define LOG_CONVERTER_ROUND_EN for round-half-up scaling and realignment (default build floors).
module log_converter
  import log_converter_pkg::*;
#(
  parameter int IN_W       = 24,
  parameter int IN_FRAC    = 8,
  parameter int OUT_W      = 12,
  parameter int OUT_FRAC   = 8,
  parameter int FRAC_ITERS = 8,
  parameter int CHANNELS   = 4,
  parameter int CW         = chan_width(CHANNELS)
) (
  input logic            clk,
  input logic            I_RSTn,
  log_converter_if.slave bus
);
  localparam int IDX_W  = $clog2(IN_W);
  localparam int INT_W  = IDX_W + 1;
  localparam int L_W    = INT_W + FRAC_ITERS;
  localparam int PROD_W = L_W + 17;
  localparam int LSHIFT = (OUT_FRAC > FRAC_ITERS) ? OUT_FRAC - FRAC_ITERS : 0;
  localparam int RSHIFT = (FRAC_ITERS > OUT_FRAC) ? FRAC_ITERS - OUT_FRAC : 0;
  localparam int WIDE_W = PROD_W + LSHIFT + 1;
  localparam int CNT_W  = $clog2(FRAC_ITERS + 1);
`ifdef LOG_CONVERTER_ROUND_EN
  localparam int ROUND_ON = 1;
`else
  localparam int ROUND_ON = 0;
`endif
  // Half-LSB offsets collapse to zero when rounding is off or there is nothing to shift.
  localparam logic signed [PROD_W-1:0] SCALE_RND = PROD_W'((ROUND_ON << SCALE_SHIFT) >> 1);
  localparam logic signed [WIDE_W-1:0] ALIGN_RND = WIDE_W'((ROUND_ON << RSHIFT) >> 1);
  localparam logic signed [WIDE_W-1:0] OUT_MAX   = WIDE_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [WIDE_W-1:0] OUT_MIN   = ~OUT_MAX;
  localparam logic signed [16:0]       K_LN      = 17'(LN2_Q16);
  localparam logic signed [16:0]       K_LOG10   = 17'(LOG10_2_Q16);

  state_t                  state_q, state_d;
  logic [IN_W-1:0]         data_q, data_d;
  logic [CW-1:0]           chan_q, chan_d;
  log_mode_t               mode_q, mode_d;
  logic                    zero_q, zero_d;
  logic signed [INT_W-1:0] int_q, int_d;
  logic [IN_W-1:0]         man_q, man_d;
  logic [FRAC_ITERS-1:0]   frac_q, frac_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [CW-1:0]           out_chan_q, out_chan_d;
  logic                    out_sat_q, out_sat_d;
  logic                    out_zero_q, out_zero_d;

  logic [IDX_W-1:0]         lead_idx;
  logic                     lead_zero;
  logic                     in_ready;
  logic                     accept;
  logic [IN_W:0]            sq_top;
  logic [IN_W-2:0]          sq_unused;
  logic signed [L_W-1:0]    l_val;
  logic signed [16:0]       k_val;
  logic signed [PROD_W-1:0] l_ext, k_ext, prod, scaled;
  logic signed [WIDE_W-1:0] wide, aligned;
  logic signed [OUT_W-1:0]  res_data;
  logic                     res_sat;

  lod_priority #(.W(IN_W), .IW(IDX_W)) u_lod (
    .vec   (data_q),
    .index (lead_idx),
    .zero  (lead_zero)
  );

  assign in_ready     = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_zero  = out_zero_q;

  // Squared mantissa kept to Q2.(IN_W-1); the low product bits are the truncation.
  always_comb begin
    {sq_top, sq_unused} = (2 * IN_W)'(man_q) * (2 * IN_W)'(man_q);
  end

  always_comb begin
    l_val = {int_q, frac_q};
    case (mode_q)
      LN:      k_val = K_LN;
      LOG10:   k_val = K_LOG10;
      default: k_val = '0;
    endcase
    l_ext = {{(PROD_W - L_W){l_val[L_W-1]}}, l_val};
    k_ext = {{(PROD_W - 17){k_val[16]}}, k_val};
    prod  = l_ext * k_ext;
    if ((mode_q == LN) || (mode_q == LOG10)) scaled = (prod + SCALE_RND) >>> SCALE_SHIFT;
    else                                     scaled = l_ext;
    wide    = {{(WIDE_W - PROD_W){scaled[PROD_W-1]}}, scaled};
    aligned = ((wide + ALIGN_RND) >>> RSHIFT) <<< LSHIFT;
    res_sat  = 1'b0;
    res_data = aligned[OUT_W-1:0];
    if (aligned > OUT_MAX) begin
      res_data = OUT_MAX[OUT_W-1:0];
      res_sat  = 1'b1;
    end else if (aligned < OUT_MIN) begin
      res_data = OUT_MIN[OUT_W-1:0];
      res_sat  = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    chan_d      = chan_q;
    mode_d      = mode_q;
    zero_d      = zero_q;
    int_d       = int_q;
    man_d       = man_q;
    frac_d      = frac_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_sat_d   = out_sat_q;
    out_zero_d  = out_zero_q;
    case (state_q)
      IDLE: ;
      NORM: begin
        int_d   = INT_W'({1'b0, lead_idx}) - INT_W'(IN_FRAC);
        man_d   = data_q << (IDX_W'(IN_W - 1) - lead_idx);
        frac_d  = '0;
        cnt_d   = '0;
        zero_d  = lead_zero;
        state_d = lead_zero ? SCALE : FRAC;
      end
      FRAC: begin
        man_d  = sq_top[IN_W] ? sq_top[IN_W:1] : sq_top[IN_W-1:0];
        frac_d = {frac_q[FRAC_ITERS-2:0], sq_top[IN_W]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FRAC_ITERS - 1)) state_d = SCALE;
      end
      SCALE: begin
        out_valid_d = 1'b1;
        out_chan_d  = chan_q;
        out_zero_d  = zero_q;
        out_sat_d   = zero_q ? 1'b0 : res_sat;
        out_data_d  = zero_q ? OUT_MIN[OUT_W-1:0] : res_data;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new request wins over the return to IDLE when it arrives as the result is consumed.
    if (accept) begin
      data_d  = bus.in_data;
      chan_d  = bus.in_chan;
      mode_d  = log_mode_t'(bus.in_mode);
      state_d = NORM;
    end
  end

  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      state_q     <= IDLE;
      data_q      <= '0;
      chan_q      <= '0;
      mode_q      <= LOG2;
      zero_q      <= 1'b0;
      int_q       <= '0;
      man_q       <= '0;
      frac_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_sat_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      chan_q      <= chan_d;
      mode_q      <= mode_d;
      zero_q      <= zero_d;
      int_q       <= int_d;
      man_q       <= man_d;
      frac_q      <= frac_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_sat_q   <= out_sat_d;
      out_zero_q  <= out_zero_d;
    end
  end

endmodule

// File: tb/tb_log_converter.sv
// Scoreboard bench for log_converter: expected results queued at accept, compared when out_valid rises.
module tb_log_converter;
  localparam int IN_W  = 24;
  localparam int OUT_W = 12;
  localparam int CW    = 2;
  localparam int LAT   = 10;

  typedef struct {
    int data;
    int chan;
    int sat;
    int zero;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;
  int   acc_cycle = 0;
  exp_t sb[$];

  log_converter_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CW(CW)) bus ();

  log_converter #(
    .IN_W(IN_W), .IN_FRAC(8), .OUT_W(OUT_W), .OUT_FRAC(8),
    .FRAC_ITERS(8), .CHANNELS(4), .CW(CW)
  ) dut (
    .clk    (clk),
    .I_RSTn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference log2 in Q.8 from real arithmetic, used only on inputs far from a fraction-bit boundary.
  function automatic int log2_q8(input logic [23:0] d);
    int  p = 0;
    real fr;
    for (int i = 0; i < 24; i++) if (d[i]) p = i;
    fr = $ln(real'(d) / real'(longint'(1) << p)) / $ln(2.0);
    return (p - 8) * 256 + int'($floor(fr * 256.0));
  endfunction

  function automatic exp_t expect_result(input logic [23:0] d, input int chan, input int mode);
    exp_t   e;
    int     l;
    real    r;
    longint v;
    e.chan = chan; e.sat = 0; e.zero = 0; e.lat = LAT;
    if (d == 24'd0) begin
      e.data = -2048; e.zero = 1; e.lat = 2;
      return e;
    end
    l = log2_q8(d);
    case (mode)
      1:       r = real'(l) * 45426.0 / 65536.0;
      2:       r = real'(l) * 19728.0 / 65536.0;
      default: r = real'(l);
    endcase
`ifdef LOG_CONVERTER_ROUND_EN
    v = longint'($floor(r + 0.5));
`else
    v = longint'($floor(r));
`endif
    if (v > 2047) begin v = 2047; e.sat = 1; end
    else if (v < -2048) begin v = -2048; e.sat = 1; end
    e.data = int'(v);
    return e;
  endfunction

  task automatic applyStimulus(input logic [23:0] d, input int chan, input int mode,
                               input bit ack, output int waits);
    bit done = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_chan  = CW'(chan);
    bus.in_mode  = 2'(mode);
    if (ack) bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 40 && !done; i++) begin
      done = bus.in_ready;
      if (!done) waits++;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (!done) checkOutput("accept_timeout", 0, 1);
    else begin
      sb.push_back(expect_result(d, chan, mode));
      acc_cycle = cycle;
    end
  endtask

  task automatic waitResult(output exp_t e);
    bit seen = 1'b0;
    e = '{default: 0};
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) checkOutput("result_timeout", 0, 1);
    else if (sb.size() == 0) checkOutput("unexpected_result", 0, 1);
    else begin
      e = sb.pop_front();
      checkOutput("data", int'(bus.out_data), e.data);
      checkOutput("chan", int'(bus.out_chan), e.chan);
      checkOutput("sat", int'(bus.out_sat), e.sat);
      checkOutput("zero", int'(bus.out_zero), e.zero);
      checkOutput("latency", cycle - acc_cycle, e.lat);
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput("valid_drop", int'(bus.out_valid), 0);
  endtask

  logic [23:0] vec_data [9] = '{24'h000100, 24'h000200, 24'h000080, 24'hFFFFFF, 24'hFFFFFF,
                                24'h000000, 24'h000300, 24'h000A00, 24'h000A00};
  int          vec_chan [9] = '{0, 1, 2, 1, 2, 3, 0, 1, 2};
  int          vec_mode [9] = '{0, 1, 1, 0, 2, 0, 0, 2, 3};

  initial begin
    exp_t e;
    int   waits;
    bit   stale;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_chan = '0; bus.in_mode = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", int'(bus.out_valid), 0);
    checkOutput("rst_data", int'(bus.out_data), 0);
    checkOutput("rst_chan", int'(bus.out_chan), 0);
    checkOutput("rst_sat", int'(bus.out_sat), 0);
    checkOutput("rst_zero", int'(bus.out_zero), 0);
    checkOutput("rst_ready", int'(bus.in_ready), 1);
    rst_n = 1'b1;

    foreach (vec_data[i]) begin
      applyStimulus(vec_data[i], vec_chan[i], vec_mode[i], 1'b0, waits);
      waitResult(e);
      consume();
    end

    for (int k = 0; k < 4; k++) begin
      applyStimulus(24'd1 << $urandom_range(0, 23), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'b0, waits);
      waitResult(e);
      consume();
    end

    // Stall the consumer, then restart with a same-cycle handoff.
    applyStimulus(24'h000300, 1, 1, 1'b0, waits);
    waitResult(e);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("hold_valid", int'(bus.out_valid), 1);
    checkOutput("hold_data", int'(bus.out_data), e.data);
    checkOutput("hold_chan", int'(bus.out_chan), e.chan);
    checkOutput("hold_sat", int'(bus.out_sat), e.sat);
    checkOutput("hold_zero", int'(bus.out_zero), e.zero);
    applyStimulus(24'h000200, 2, 2, 1'b1, waits);
    checkOutput("handoff_waits", waits, 0);
    checkOutput("handoff_drop", int'(bus.out_valid), 0);
    waitResult(e);
    consume();

    // Reset in the middle of the squaring loop must drop the request.
    applyStimulus(24'hFFFFFF, 0, 0, 1'b0, waits);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    checkOutput("midrst_valid", int'(bus.out_valid), 0);
    checkOutput("midrst_ready", int'(bus.in_ready), 1);
    stale = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale = 1'b1;
    end
    checkOutput("midrst_stale", int'(stale), 0);

    applyStimulus(24'h000100, 3, 0, 1'b0, waits);
    waitResult(e);
    consume();
    checkOutput("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/log_converter.md
Name: log_converter

Overview:
- Parametrised, multi-channel fixed-point logarithm engine for the discrete-audio models.
- Supports selectable base: log2, ln or log10.
- Accepts unsigned fixed-point samples through a valid/ready handshake and computes an exact-iteration log2: leading-one normalise, then mantissa squaring.
- Scales the log2 result by a per-base constant and returns a signed, saturated, channel-tagged result.
- Handles inputs below 1.0 and zero, which a clamp-based log cannot.

Parameters:
- IN_W, 24, input width (unsigned).
- IN_FRAC, 8, fractional bits of input.
- OUT_W, 12, output width (signed two's complement).
- OUT_FRAC, 8, fractional bits of output.
- FRAC_ITERS, 8, log2 fractional bits computed (one squaring per cycle).
- CHANNELS, 4, number of channel tags; tag width CW = max(1, $clog2(CHANNELS)).

Ports:
- clk  in  1  system clock
- I_RSTn  in  1  synchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid & in_ready at rising edge
- in_data  in  IN_W  unsigned sample, IN_FRAC fractional bits
- in_chan  in  CW  channel tag
- in_mode  in  2  0=log2, 1=ln, 2=log10, 3=reserved (treated as log2)
- out_valid  out  1  result present; held until out_ready
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  signed log result, OUT_FRAC fractional bits
- out_chan  out  CW  tag of the request
- out_sat  out  1  result was clamped to the OUT_W range
- out_zero  out  1  input was 0; out_data = most negative value

Behaviour:
- Reset (I_RSTn low at an edge): state IDLE; out_valid=0, out_data=0, out_chan=0, out_sat=0, out_zero=0. Any in-flight request is discarded, including one reset mid-iteration.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back throughput is one result per FRAC_ITERS+3 cycles.
- IDLE: on accept, latch data, chan and mode; go to NORM.
- NORM (1 cycle): find p = index of leading one.
  - Integer log part = p - IN_FRAC (signed, may be negative).
  - Mantissa = data shifted so the leading one sits at bit IN_W-1, i.e. Q1.(IN_W-1) in [1,2).
  - If data==0: set zero flag and skip to SCALE.
- FRAC (FRAC_ITERS cycles): each cycle m = m*m, truncated to Q2.(IN_W-1).
  - If m>=2: emit fraction bit 1 and m = m>>1; else emit 0.
  - Bits are emitted MSB first.
- SCALE (1 cycle): L = {int, frac}, signed, FRAC_ITERS fractional bits.
  - log2 mode: R = L.
  - ln mode: R = (L*LN2_Q16)>>>16.
  - log10 mode: R = (L*LOG10_2_Q16)>>>16.
  - Arithmetic shift means floor. Then realign from FRAC_ITERS to OUT_FRAC fractional bits (shift, floor).
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set out_sat if clamped.
  - Zero input forces out_data = -2^(OUT_W-1), out_zero=1, out_sat=0.
  - Go to DONE with out_valid=1.
- Latency: accept edge to out_valid high = FRAC_ITERS+2 edges (10 at defaults).
- DONE: outputs stable while out_valid & !out_ready.
  - out_ready without in_valid: go to IDLE; out_valid=0 next cycle.
  - out_ready and in_valid same cycle: new request accepted; go to NORM; out_valid drops.
- Intermediate product width: (int width + FRAC_ITERS + 17) bits. No overflow is permitted before saturation.

Optional Feature:
- LOG_CONVERTER_ROUND_EN
  - Defined: SCALE and realignment use round-half-up (add 2^(shift-1) before shift).
  - Undefined: floor as above.

Decomposition:
- log_converter_pkg holds:
  - log_mode_t enum (LOG2, LN, LOG10, RSVD).
  - state_t enum (IDLE, NORM, FRAC, SCALE, DONE).
  - LN2_Q16 = 45426.
  - LOG10_2_Q16 = 19728.
- One sub-module: lod_priority, a combinational leading-one detector with a parametrised width.
  - Outputs: index, and a zero flag.

Test Plan:
- log2 mode, in_data=0x000100 (1.0) -> out_data=0, flags 0, out_valid 10 cycles after accept.
- ln mode, 0x000200 -> 177. ln mode, 0x000080 -> -178 (floor; -177 with LOG_CONVERTER_ROUND_EN).
- log2 mode, 0xFFFFFF -> 2047, out_sat=1. log10 mode, 0xFFFFFF -> 1232 (1233 with ROUND_EN), out_sat=0.
- in_data=0 on chan 3 -> out_data=-2048, out_zero=1, out_chan=3.
- Hold out_ready=0 for 5 cycles -> out_data, out_chan and flags stable. Raise out_ready with in_valid -> same-cycle accept, next result 10 cycles later.
- Pulse I_RSTn low during FRAC -> out_valid stays 0, in_ready=1 next cycle, no stale result emitted.
